// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl - parametrised UART with TX/RX FIFOs for the CPU peripheral bus.
//
// Purpose
//   Serialises words from a TX FIFO onto txd and deserialises rxd into an RX
//   FIFO. Frame format (divisor, parity enable/polarity, one or two stop bits)
//   is latched separately by TX and RX at the start of every frame.
//
// Ports
//   clk, rst                  system clock, asynchronous active-high reset
//   divisor                   clocks per bit minus 1 (>= 3)
//   parity_en, parity_odd     parity bit enable and polarity
//   stop2                     two stop bits on TX (RX checks only the first)
//   tx_data, tx_wr            word and push strobe for the TX FIFO
//   tx_full, tx_busy          TX FIFO full; shifter active or FIFO non-empty
//   rx_data, rx_rd, rx_empty  first-word fall-through RX FIFO head, pop, empty
//   err_clr                   clears the sticky error flags
//   rx_overrun, rx_frame_err, rx_parity_err   sticky receive errors
//   irq                       RX data available or any sticky error
//   rxd, txd                  serial in (asynchronous) / serial out (idle high)

// Synchronous FIFO with first-word fall-through head and occupancy count.
module uart_fifo_ctrl_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CNT_MAX);
  assign empty     = (count_r == '0);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];

  // Storage array; contents are qualified by the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

module uart_fifo_ctrl #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 3,
  parameter int DIV_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  divisor,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic              tx_busy,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_rd,
  output logic              rx_empty,
  input  logic              err_clr,
  output logic              rx_overrun,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              irq,
  input  logic              rxd,
  output logic              txd
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0]    BIT_ONE  = BW'(1'b1);
  localparam logic [BW-1:0]    BIT_LAST = BW'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_STOP2  = 3'd5
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Parity over the data bits, inverted for odd parity.
  function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic odd);
    parity_of = (^d) ^ odd;
  endfunction

  // ---------------------------------------------------------------- TX path
  tx_state_t         tx_state_r, tx_state_n;
  logic [DIV_W-1:0]  tx_cnt_r, tx_cnt_n;
  logic [BW-1:0]     tx_bit_r, tx_bit_n;
  logic [DATA_W-1:0] tx_shift_r, tx_shift_n;
  logic              tx_par_r, tx_par_n;
  logic [DIV_W-1:0]  tx_div_r, tx_div_n;
  logic              tx_par_en_r, tx_par_en_n;
  logic              tx_stop2_r, tx_stop2_n;
  logic              txd_r, txd_n;
  logic              tx_tick_s;
  logic              tx_load_s;
  logic [DATA_W-1:0] tx_head_s;
  logic              tx_empty_s;

  uart_fifo_ctrl_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr),
    .wdata (tx_data),
    .pop   (tx_load_s),
    .head  (tx_head_s),
    .full  (tx_full),
    .empty (tx_empty_s)
  );

  // TX next-state: bit timing, shifting, and FIFO pop with config latch
  always_comb begin
    tx_state_n  = tx_state_r;
    tx_cnt_n    = tx_cnt_r;
    tx_bit_n    = tx_bit_r;
    tx_shift_n  = tx_shift_r;
    tx_par_n    = tx_par_r;
    tx_div_n    = tx_div_r;
    tx_par_en_n = tx_par_en_r;
    tx_stop2_n  = tx_stop2_r;
    tx_load_s   = 1'b0;
    txd_n       = 1'b1;
    tx_tick_s   = (tx_cnt_r == tx_div_r);

    case (tx_state_r)
      TX_IDLE: begin
        if (!tx_empty_s) begin
          tx_load_s = 1'b1;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_tick_s) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
        end else begin
          tx_cnt_n = tx_cnt_r + DIV_ONE;
        end
      end
      TX_DATA: begin
        if (tx_tick_s) begin
          tx_cnt_n = '0;
          if (tx_bit_r == BIT_LAST) begin
            tx_state_n = tx_par_en_r ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_n   = tx_bit_r + BIT_ONE;
            tx_shift_n = {1'b0, tx_shift_r[DATA_W-1:1]};
          end
        end else begin
          tx_cnt_n = tx_cnt_r + DIV_ONE;
        end
      end
      TX_PARITY: begin
        if (tx_tick_s) begin
          tx_state_n = TX_STOP;
          tx_cnt_n   = '0;
        end else begin
          tx_cnt_n = tx_cnt_r + DIV_ONE;
        end
      end
      TX_STOP: begin
        if (tx_tick_s) begin
          tx_cnt_n = '0;
          if (tx_stop2_r) begin
            tx_state_n = TX_STOP2;
          end else if (!tx_empty_s) begin
            tx_load_s = 1'b1;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt_r + DIV_ONE;
        end
      end
      TX_STOP2: begin
        if (tx_tick_s) begin
          tx_cnt_n = '0;
          if (!tx_empty_s) begin
            tx_load_s = 1'b1;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt_r + DIV_ONE;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = '0;
      end
    endcase

    // A pop (from IDLE or at the end of a stop bit) starts the next frame
    // immediately, which gives back-to-back frames without an idle gap.
    if (tx_load_s) begin
      tx_state_n  = TX_START;
      tx_cnt_n    = '0;
      tx_shift_n  = tx_head_s;
      tx_par_n    = parity_of(tx_head_s, parity_odd);
      tx_div_n    = divisor;
      tx_par_en_n = parity_en;
      tx_stop2_n  = stop2;
    end else begin
      tx_state_n = tx_state_n;
    end

    // txd is registered from the next state so it changes with the state itself
    case (tx_state_n)
      TX_START:  txd_n = 1'b0;
      TX_DATA:   txd_n = tx_shift_n[0];
      TX_PARITY: txd_n = tx_par_n;
      default:   txd_n = 1'b1;
    endcase
  end

  // TX state register; reset returns txd high at once, aborting any frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_r  <= TX_IDLE;
      tx_cnt_r    <= '0;
      tx_bit_r    <= '0;
      tx_shift_r  <= '0;
      tx_par_r    <= 1'b0;
      tx_div_r    <= '0;
      tx_par_en_r <= 1'b0;
      tx_stop2_r  <= 1'b0;
      txd_r       <= 1'b1;
    end else begin
      tx_state_r  <= tx_state_n;
      tx_cnt_r    <= tx_cnt_n;
      tx_bit_r    <= tx_bit_n;
      tx_shift_r  <= tx_shift_n;
      tx_par_r    <= tx_par_n;
      tx_div_r    <= tx_div_n;
      tx_par_en_r <= tx_par_en_n;
      tx_stop2_r  <= tx_stop2_n;
      txd_r       <= txd_n;
    end
  end

  assign txd     = txd_r;
  assign tx_busy = (tx_state_r != TX_IDLE) | ~tx_empty_s;

  // ---------------------------------------------------------------- RX path
  rx_state_t         rx_state_r, rx_state_n;
  logic [DIV_W-1:0]  rx_cnt_r, rx_cnt_n;
  logic [BW-1:0]     rx_bit_r, rx_bit_n;
  logic [DATA_W-1:0] rx_shift_r, rx_shift_n;
  logic              rx_pbit_r, rx_pbit_n;
  logic [DIV_W-1:0]  rx_div_r, rx_div_n;
  logic [DIV_W-1:0]  rx_half_r, rx_half_n;
  logic              rx_par_en_r, rx_par_en_n;
  logic              rx_odd_r, rx_odd_n;
  logic              rx_sync1_r, rx_sync2_r, rx_prev_r;
  logic              rx_fall_s;
  logic              rx_tick_s;
  logic              rx_stop_s;
  logic              rx_full_s;
  logic              rx_empty_s;
  logic [DATA_W-1:0] rx_head_s;
  logic [DIV_W-1:0]  half_s;
  logic              set_ovr_s, set_frame_s, set_par_s;
  logic              rx_overrun_r, rx_frame_err_r, rx_parity_err_r;

  // (divisor+1)/2 without overflowing DIV_W bits; minus one because the
  // detect cycle itself already lies inside the start bit.
  assign half_s    = {1'b0, divisor[DIV_W-1:1]} + {{(DIV_W-1){1'b0}}, divisor[0]} - DIV_ONE;
  assign rx_fall_s = rx_prev_r & ~rx_sync2_r;
  assign rx_tick_s = (rx_cnt_r == rx_div_r);

  // Two-flop synchroniser plus one history flop for start-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
    end else begin
      rx_sync1_r <= rxd;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
    end
  end

  // RX next-state: centre sampling of each bit, glitch rejection at start
  always_comb begin
    rx_state_n  = rx_state_r;
    rx_cnt_n    = rx_cnt_r;
    rx_bit_n    = rx_bit_r;
    rx_shift_n  = rx_shift_r;
    rx_pbit_n   = rx_pbit_r;
    rx_div_n    = rx_div_r;
    rx_half_n   = rx_half_r;
    rx_par_en_n = rx_par_en_r;
    rx_odd_n    = rx_odd_r;
    rx_stop_s   = 1'b0;

    case (rx_state_r)
      RX_IDLE: begin
        if (rx_fall_s) begin
          rx_state_n  = RX_START;
          rx_cnt_n    = '0;
          rx_div_n    = divisor;
          rx_half_n   = half_s;
          rx_par_en_n = parity_en;
          rx_odd_n    = parity_odd;
        end else begin
          rx_state_n = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == rx_half_r) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          // Line back high at mid-start: treat as a glitch and drop it silently
          rx_state_n = rx_sync2_r ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt_r + DIV_ONE;
        end
      end
      RX_DATA: begin
        if (rx_tick_s) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync2_r, rx_shift_r[DATA_W-1:1]};
          if (rx_bit_r == BIT_LAST) begin
            rx_state_n = rx_par_en_r ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_n = rx_bit_r + BIT_ONE;
          end
        end else begin
          rx_cnt_n = rx_cnt_r + DIV_ONE;
        end
      end
      RX_PARITY: begin
        if (rx_tick_s) begin
          rx_cnt_n   = '0;
          rx_pbit_n  = rx_sync2_r;
          rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt_r + DIV_ONE;
        end
      end
      RX_STOP: begin
        if (rx_tick_s) begin
          // Leave at mid-stop so a start edge right after it is not missed
          rx_cnt_n   = '0;
          rx_stop_s  = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          rx_cnt_n = rx_cnt_r + DIV_ONE;
        end
      end
      default: begin
        rx_state_n = RX_IDLE;
        rx_cnt_n   = '0;
      end
    endcase
  end

  // RX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_r  <= RX_IDLE;
      rx_cnt_r    <= '0;
      rx_bit_r    <= '0;
      rx_shift_r  <= '0;
      rx_pbit_r   <= 1'b0;
      rx_div_r    <= '0;
      rx_half_r   <= '0;
      rx_par_en_r <= 1'b0;
      rx_odd_r    <= 1'b0;
    end else begin
      rx_state_r  <= rx_state_n;
      rx_cnt_r    <= rx_cnt_n;
      rx_bit_r    <= rx_bit_n;
      rx_shift_r  <= rx_shift_n;
      rx_pbit_r   <= rx_pbit_n;
      rx_div_r    <= rx_div_n;
      rx_half_r   <= rx_half_n;
      rx_par_en_r <= rx_par_en_n;
      rx_odd_r    <= rx_odd_n;
    end
  end

  // Words with frame/parity errors are still stored; only a full FIFO drops them
  assign set_ovr_s   = rx_stop_s & rx_full_s;
  assign set_frame_s = rx_stop_s & ~rx_sync2_r;
  assign set_par_s   = rx_stop_s & rx_par_en_r & (rx_pbit_r != parity_of(rx_shift_r, rx_odd_r));

  uart_fifo_ctrl_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_stop_s),
    .wdata (rx_shift_r),
    .pop   (rx_rd),
    .head  (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s)
  );

  // Sticky error flags; a new event wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_overrun_r    <= 1'b0;
      rx_frame_err_r  <= 1'b0;
      rx_parity_err_r <= 1'b0;
    end else begin
      if (set_ovr_s) begin
        rx_overrun_r <= 1'b1;
      end else if (err_clr) begin
        rx_overrun_r <= 1'b0;
      end else begin
        rx_overrun_r <= rx_overrun_r;
      end
      if (set_frame_s) begin
        rx_frame_err_r <= 1'b1;
      end else if (err_clr) begin
        rx_frame_err_r <= 1'b0;
      end else begin
        rx_frame_err_r <= rx_frame_err_r;
      end
      if (set_par_s) begin
        rx_parity_err_r <= 1'b1;
      end else if (err_clr) begin
        rx_parity_err_r <= 1'b0;
      end else begin
        rx_parity_err_r <= rx_parity_err_r;
      end
    end
  end

  // Stale memory is masked so an empty FIFO always presents zero
  assign rx_data       = rx_empty_s ? '0 : rx_head_s;
  assign rx_empty      = rx_empty_s;
  assign rx_overrun    = rx_overrun_r;
  assign rx_frame_err  = rx_frame_err_r;
  assign rx_parity_err = rx_parity_err_r;
  assign irq           = ~rx_empty_s | rx_overrun_r | rx_frame_err_r | rx_parity_err_r;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
module tb_uart_fifo_ctrl;
  localparam int DATA_W  = 8;
  localparam int FIFO_AW = 3;
  localparam int DIV_W   = 16;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int BIT     = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DIV_W-1:0]  divisor = 16'd6;
  logic              parity_en = 1'b0;
  logic              parity_odd = 1'b0;
  logic              stop2 = 1'b0;
  logic [DATA_W-1:0] tx_data = 8'h00;
  logic              tx_wr = 1'b0;
  logic              tx_full, tx_busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_rd = 1'b0;
  logic              rx_empty;
  logic              err_clr = 1'b0;
  logic              rx_overrun, rx_frame_err, rx_parity_err, irq;
  logic              rxd_drv = 1'b1;
  logic              loop_en = 1'b0;
  logic              rxd_w;
  logic              txd;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] got_d;
  logic       got_p;
  bit         ok;
  logic [9:0] fr;
  int         low_cnt;

  assign rxd_w = loop_en ? txd : rxd_drv;

  uart_fifo_ctrl #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .divisor(divisor), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_full(tx_full), .tx_busy(tx_busy), .rx_data(rx_data), .rx_rd(rx_rd),
    .rx_empty(rx_empty), .err_clr(err_clr), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .irq(irq),
    .rxd(rxd_w), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tx_push(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Waits (bounded) for the first negedge on which txd reads 0.
  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (txd === 1'b0) seen = 1'b1;
    end
    check("tx_start_seen", {31'd0, seen}, 32'd1);
  endtask

  // Entered on the first start-bit cycle; samples bit centres and returns on
  // the first cycle after the stop bit (where a back-to-back start would be).
  task automatic tx_frame(input bit with_par, output logic [7:0] d, output logic p);
    repeat (3) @(negedge clk);
    check("tx_start_bit", {31'd0, txd}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (BIT) @(negedge clk);
      d[k] = txd;
    end
    p = 1'b0;
    if (with_par) begin
      repeat (BIT) @(negedge clk);
      p = txd;
    end
    repeat (BIT) @(negedge clk);
    check("tx_stop_bit", {31'd0, txd}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stopv);
    rxd_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd_drv = d[k];
      repeat (BIT) @(negedge clk);
    end
    rxd_drv = stopv;
    repeat (BIT) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic rx_pop_check(input string tag);
    logic [7:0] exp;
    exp = rx_q.pop_front();
    check({tag, "_empty"}, {31'd0, rx_empty}, 32'd0);
    check(tag, {24'd0, rx_data}, {24'd0, exp});
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_tx_full", {31'd0, tx_full}, 32'd0);
    check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_flags", {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- 1: exact 8N1 waveform of 0x69, 7 clocks per bit, 1-clock start latency
    fr = {1'b1, 8'h69, 1'b0};
    tx_push(8'h69);
    check("t1_txd_idle", {31'd0, txd}, 32'd1);
    check("t1_busy_early", {31'd0, tx_busy}, 32'd1);
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      check("t1_txd", {31'd0, txd}, {31'd0, fr[(n-1)/BIT]});
    end
    check("t1_busy_stop", {31'd0, tx_busy}, 32'd1);
    @(negedge clk);
    check("t1_txd_after", {31'd0, txd}, 32'd1);
    check("t1_busy_after", {31'd0, tx_busy}, 32'd0);

    // ---- 2: receive 0x53 8N1
    rx_q.push_back(8'h53);
    rx_send(8'h53, 1'b1);
    repeat (3) @(negedge clk);
    check("t2_irq", {31'd0, irq}, 32'd1);
    rx_pop_check("t2_rx_data");
    check("t2_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("t2_irq_clear", {31'd0, irq}, 32'd0);

    // ---- 3: DEPTH+2 pushes while idle; one pop happens early, last push drops
    fork
      begin
        for (int i = 0; i < DEPTH + 2; i++) begin
          @(negedge clk);
          tx_data = 8'(8'hC0 + i);
          tx_wr = 1'b1;
          if (i < DEPTH + 1) tx_q.push_back(tx_data);
        end
        @(negedge clk);
        tx_wr = 1'b0;
        check("t3_tx_full", {31'd0, tx_full}, 32'd1);
      end
      begin
        wait_start(ok);
        for (int i = 0; i < DEPTH + 1; i++) begin
          if (i > 0) check("t3_b2b_start", {31'd0, txd}, 32'd0);
          tx_frame(1'b0, got_d, got_p);
          check("t3_word", {24'd0, got_d}, {24'd0, tx_q.pop_front()});
        end
      end
    join
    low_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    check("t3_no_extra_frame", low_cnt, 32'd0);
    check("t3_busy_done", {31'd0, tx_busy}, 32'd0);
    check("t3_tx_q_drained", tx_q.size(), 32'd0);

    // ---- 4: odd parity on TX, RX latches even parity -> parity error via loopback
    loop_en = 1'b1;
    parity_en = 1'b1;
    parity_odd = 1'b1;
    tx_q.push_back(8'h69);
    rx_q.push_back(8'h69);
    tx_push(8'h69);
    @(negedge clk);
    parity_odd = 1'b0;
    check("t4_start", {31'd0, txd}, 32'd0);
    tx_frame(1'b1, got_d, got_p);
    check("t4_tx_word", {24'd0, got_d}, {24'd0, tx_q.pop_front()});
    check("t4_parity_bit", {31'd0, got_p}, 32'd1);
    repeat (4) @(negedge clk);
    check("t4_parity_err", {31'd0, rx_parity_err}, 32'd1);
    check("t4_frame_err", {31'd0, rx_frame_err}, 32'd0);
    rx_pop_check("t4_rx_data");
    check("t4_irq_err", {31'd0, irq}, 32'd1);
    pulse_err_clr();
    check("t4_parity_clr", {31'd0, rx_parity_err}, 32'd0);
    check("t4_irq_clr", {31'd0, irq}, 32'd0);
    loop_en = 1'b0;
    parity_en = 1'b0;

    // ---- 5: fill RX FIFO, one extra frame overruns, contents unchanged
    for (int i = 0; i < DEPTH; i++) begin
      rx_q.push_back(8'(8'h11 + 8'(i * 37)));
      rx_send(rx_q[rx_q.size() - 1], 1'b1);
    end
    check("t5_no_overrun_yet", {31'd0, rx_overrun}, 32'd0);
    rx_send(8'hEE, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_overrun", {31'd0, rx_overrun}, 32'd1);
    for (int i = 0; i < DEPTH; i++) rx_pop_check("t5_rx_data");
    check("t5_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("t5_irq_sticky", {31'd0, irq}, 32'd1);
    pulse_err_clr();
    check("t5_overrun_clr", {31'd0, rx_overrun}, 32'd0);
    rxd_drv = 1'b0;
    repeat (2) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (80) @(negedge clk);
    check("t5_glitch_empty", {31'd0, rx_empty}, 32'd1);
    check("t5_glitch_flags", {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);

    // ---- 6: reset mid data bit, then a clean frame; RX stop bit forced low
    tx_push(8'h3C);
    wait_start(ok);
    repeat (20) @(negedge clk);
    check("t6_pre_rst_txd", {31'd0, txd}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_txd", {31'd0, txd}, 32'd1);
    check("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle_txd", {31'd0, txd}, 32'd1);
    tx_q.push_back(8'hA5);
    tx_push(8'hA5);
    wait_start(ok);
    tx_frame(1'b0, got_d, got_p);
    check("t6_tx_word", {24'd0, got_d}, {24'd0, tx_q.pop_front()});
    rx_q.push_back(8'h5A);
    rx_send(8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_frame_err", {31'd0, rx_frame_err}, 32'd1);
    rx_pop_check("t6_rx_data");
    check("t6_irq_frame", {31'd0, irq}, 32'd1);
    pulse_err_clr();
    check("t6_irq_clr", {31'd0, irq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
